note_voice_scheduler: RTL

Sequences the raw PS/2 scan-code stream into piano note events and allocates them onto a fixed pool of tone-generator voices. It sits between the keyboard receiver (`scan_code_ready` strobe plus `scan_code` byte) and the per-voice tone generators. It tracks make/break/extended prefixes, maps keys to note indices, and arbitrates voices with lowest-free-first allocation and round-robin stealing when all voices are busy.

---
 rtl/piano_pkg.sv | 43 ++++
 rtl/note_voice_scheduler_scan_to_note.sv | 24 ++
 rtl/note_voice_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
//------------------------------------------------------------------------------
// piano_pkg : scan-code constants, prefix FSM state type, key-to-note map. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package piano_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXTEND = 8'hE0;
  localparam logic [3:0] NOTE_NONE = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

  // Returns {valid, note}; unmapped codes give valid=0 and NOTE_NONE.
  function automatic logic [4:0] key_to_note(input logic [7:0] code);
    logic [4:0] r;
    case (code)
      8'h1C:   r = {1'b1, 4'd0};
      8'h1D:   r = {1'b1, 4'd1};
      8'h1B:   r = {1'b1, 4'd2};
      8'h24:   r = {1'b1, 4'd3};
      8'h23:   r = {1'b1, 4'd4};
      8'h2B:   r = {1'b1, 4'd5};
      8'h2C:   r = {1'b1, 4'd6};
      8'h34:   r = {1'b1, 4'd7};
      8'h35:   r = {1'b1, 4'd8};
      8'h33:   r = {1'b1, 4'd9};
      8'h3C:   r = {1'b1, 4'd10};
      8'h3B:   r = {1'b1, 4'd11};
      8'h42:   r = {1'b1, 4'd12};
      default: r = {1'b0, NOTE_NONE};
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/note_voice_scheduler_scan_to_note.sv
//------------------------------------------------------------------------------
// scan_to_note : combinational scan-code byte to {valid, note} lookup. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module scan_to_note
  import piano_pkg::*;
#(
  parameter int NOTE_W = 4
) (
  input  logic [7:0]        code,
  output logic              valid,
  output logic [NOTE_W-1:0] note
);

  logic [4:0] lookup;

  assign lookup = key_to_note(code);
  assign valid  = lookup[4];
  assign note   = NOTE_W'(lookup[3:0]);

endmodule

`default_nettype wire

// File: rtl/note_voice_scheduler.sv
//------------------------------------------------------------------------------
// note_voice_scheduler : PS/2 prefix decode and voice allocation/stealing. Rev 1.0
// Optional: NOTE_VOICE_TYPEMATIC_FILTER_EN ignores repeated makes of held notes.
//------------------------------------------------------------------------------
`default_nettype none

module note_voice_scheduler
  import piano_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int NOTE_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scan_code_ready,
  input  logic [7:0]               scan_code,
  output logic [VOICES-1:0]        voice_active,
  output logic [VOICES*NOTE_W-1:0] voice_note,
  output logic [VOICES-1:0]        voice_trig,
  output logic                     voice_steal
);

  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [NOTE_W-1:0] NONE_CODE = NOTE_W'(NOTE_NONE);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(VOICES - 1);

  prefix_state_t state, state_next;
  logic is_make, is_break;

  logic              key_valid;
  logic [NOTE_W-1:0] key_note;

  logic [NOTE_W-1:0] note_r [VOICES];
  logic [IDX_W-1:0]  steal_ptr;

  logic             hit_any, free_any;
  logic [IDX_W-1:0] hit_idx, free_idx;

  scan_to_note #(.NOTE_W(NOTE_W)) u_scan_to_note (
    .code  (scan_code),
    .valid (key_valid),
    .note  (key_note)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    is_make    = 1'b0;
    is_break   = 1'b0;
    if (scan_code_ready) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == SC_BREAK)       state_next = ST_BRK;
          else if (scan_code == SC_EXTEND) state_next = ST_EXT;
          else                             is_make    = 1'b1;
        end
        ST_EXT: begin
          if (scan_code == SC_BREAK) state_next = ST_EXT_BRK;
          else                       state_next = ST_IDLE;
        end
        ST_BRK: begin
          if (scan_code == SC_BREAK)       state_next = ST_BRK;
          else if (scan_code == SC_EXTEND) state_next = ST_EXT_BRK;
          else begin
            is_break   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Downward scans so the lowest matching index wins.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (voice_active[v] && (note_r[v] == key_note)) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(v);
      end
      if (!voice_active[v]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(v);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      voice_active <= '0;
      voice_trig   <= '0;
      voice_steal  <= 1'b0;
      steal_ptr    <= '0;
      for (int v = 0; v < VOICES; v++) note_r[v] <= NONE_CODE;
    end else begin
      voice_trig  <= '0;
      voice_steal <= 1'b0;
      if (is_make && key_valid) begin
        if (hit_any) begin
`ifdef NOTE_VOICE_TYPEMATIC_FILTER_EN
          voice_trig <= '0;
`else
          voice_trig[hit_idx] <= 1'b1;
`endif
        end else if (free_any) begin
          voice_active[free_idx] <= 1'b1;
          note_r[free_idx]       <= key_note;
          voice_trig[free_idx]   <= 1'b1;
        end else begin
          note_r[steal_ptr]     <= key_note;
          voice_trig[steal_ptr] <= 1'b1;
          voice_steal           <= 1'b1;
          steal_ptr             <= (steal_ptr == LAST_IDX) ? '0 : steal_ptr + 1'b1;
        end
      end else if (is_break && key_valid && hit_any) begin
        voice_active[hit_idx] <= 1'b0;
        note_r[hit_idx]       <= NONE_CODE;
      end
    end
  end

  generate
    for (genvar v = 0; v < VOICES; v++) begin : g_note_out
      assign voice_note[v*NOTE_W +: NOTE_W] = note_r[v];
    end
  endgenerate

endmodule

`default_nettype wire
